// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_pkg
//  Description : Shared SECDED definitions: check-bit sizing, codeword
//                position mapping and decode status encoding.
//  Revision    : 1.0
// ============================================================================
package hamming_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        CE    = 2'd1,
        UE    = 2'd2
    } secded_status_t;

    function automatic bit is_pow2(input int val);
        return (val > 0) && ((val & (val - 1)) == 0);
    endfunction

    // Smallest r with 2^r >= width + r + 1.
    function automatic int calc_checkb(input int width);
        int  r;
        bit  found;
        r     = 1;
        found = 1'b0;
        for (int k = 1; k < 31; k++) begin
            if (!found && ((1 << k) >= width + k + 1)) begin
                r     = k;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Data bits fill the non-power-of-two positions from 3 upward.
    function automatic int cw_pos_of_data(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= idx + 34; p++) begin
            if (!is_pow2(p)) begin
                if ((cnt == idx) && (pos == 0)) begin
                    pos = p;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage : hamming_pkg
`default_nettype wire

// File: rtl/hamming_secded_syn.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_secded_syn
//  Description : Combinational extended-Hamming syndrome and overall parity.
//  Revision    : 1.0
// ============================================================================
module hamming_secded_syn #(
    parameter int CW_WIDTH = 16,
    parameter int N_CHECKB = 4
) (
    input  logic [CW_WIDTH-1:0] cw,
    output logic [N_CHECKB-1:0] syn,
    output logic                par
);

    // Syndrome is the XOR of the indices of every set bit except bit 0.
    always_comb begin
        syn = '0;
        for (int i = 1; i < CW_WIDTH; i++) begin
            if (cw[i]) begin
                syn = syn ^ N_CHECKB'(i);
            end
        end
        par = ^cw;
    end

endmodule : hamming_secded_syn
`default_nettype wire

// File: rtl/hamming_secded_dec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_secded_dec_pipe
//  Description : Two-stage pipelined SECDED decoder with valid/ready handshake,
//                saturating error counters and last-error syndrome capture.
//  Revision    : 1.0
// ============================================================================
module hamming_secded_dec_pipe
    import hamming_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int N_CHECKB   = calc_checkb(DATA_WIDTH),
    parameter int CW_WIDTH   = DATA_WIDTH + N_CHECKB + 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [CW_WIDTH-1:0]   cw_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  ce_o,
    output logic                  ue_o,
    output logic [CNT_WIDTH-1:0]  ce_cnt_o,
    output logic [CNT_WIDTH-1:0]  ue_cnt_o,
    output logic [N_CHECKB-1:0]   last_syn_o,
    input  logic                  clr_cnt_i
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    generate
        if (DATA_WIDTH < 4) begin : g_bad_data_width
            $error("hamming_secded_dec_pipe: DATA_WIDTH must be >= 4");
        end
        if ((1 << N_CHECKB) < CW_WIDTH) begin : g_bad_checkb
            $error("hamming_secded_dec_pipe: N_CHECKB too small for CW_WIDTH");
        end
        if (CW_WIDTH != DATA_WIDTH + N_CHECKB + 1) begin : g_bad_cw_width
            $error("hamming_secded_dec_pipe: CW_WIDTH inconsistent with DATA_WIDTH/N_CHECKB");
        end
    endgenerate

    logic                  s1_en;
    logic                  s2_en;
    logic                  s1_valid;
    logic                  s2_valid;
    logic                  out_hs;

    logic [N_CHECKB-1:0]   in_syn;
    logic                  in_par;
    logic [DATA_WIDTH-1:0] in_data;

    logic [DATA_WIDTH-1:0] s1_data;
    logic [N_CHECKB-1:0]   s1_syn;
    logic                  s1_par;

    secded_status_t        status;
    logic [DATA_WIDTH-1:0] fixed_data;
    logic [N_CHECKB-1:0]   s2_syn;

    // ------------------------------------------------------------------
    // Handshake: no skid buffer, ready ripples back from out_ready_i
    // ------------------------------------------------------------------
    assign s2_en       = !s2_valid || out_ready_i;
    assign s1_en       = !s1_valid || s2_en;
    assign in_ready_o  = s1_en;
    assign out_valid_o = s2_valid;
    assign out_hs      = s2_valid && out_ready_i;

    hamming_secded_syn #(
        .CW_WIDTH (CW_WIDTH),
        .N_CHECKB (N_CHECKB)
    ) u_syn (
        .cw  (cw_i),
        .syn (in_syn),
        .par (in_par)
    );

    // Stage 1 keeps the raw payload; check bits only feed the syndrome.
    generate
        for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_extract
            localparam int POS = cw_pos_of_data(d);
            assign in_data[d] = cw_i[POS];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_data <= in_data;
                s1_syn  <= in_syn;
                s1_par  <= in_par;
            end
        end
    end

    // ------------------------------------------------------------------
    // Classification and correction
    // ------------------------------------------------------------------
    always_comb begin
        status = CLEAN;
        if (s1_par) begin
            status = (32'(s1_syn) < CW_WIDTH) ? CE : UE;
        end else if (s1_syn != '0) begin
            status = UE;
        end
    end

    // Only a data position can be the target of a correction that matters.
    generate
        for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_correct
            localparam int POS = cw_pos_of_data(d);
            assign fixed_data[d] = s1_data[d] ^
                                   ((status == CE) && (s1_syn == N_CHECKB'(POS)));
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            data_o   <= '0;
            ce_o     <= 1'b0;
            ue_o     <= 1'b0;
            s2_syn   <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                data_o <= fixed_data;
                ce_o   <= (status == CE);
                ue_o   <= (status == UE);
                s2_syn <= s1_syn;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error statistics, updated only when a result is consumed
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ce_cnt_o   <= '0;
            ue_cnt_o   <= '0;
            last_syn_o <= '0;
        end else if (clr_cnt_i) begin
            ce_cnt_o   <= '0;
            ue_cnt_o   <= '0;
            last_syn_o <= '0;
        end else if (out_hs) begin
            if (ce_o && (ce_cnt_o != CNT_MAX)) begin
                ce_cnt_o <= ce_cnt_o + CNT_WIDTH'(1);
            end
            if (ue_o && (ue_cnt_o != CNT_MAX)) begin
                ue_cnt_o <= ue_cnt_o + CNT_WIDTH'(1);
            end
            if (ce_o || ue_o) begin
                last_syn_o <= s2_syn;
            end
        end
    end

endmodule : hamming_secded_dec_pipe
`default_nettype wire

// File: tb/tb_hamming_secded_dec_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_secded_dec_pipe
//  Description : Randomized self-checking bench with a behavioural SECDED model.
//  Revision    : 1.0
// ============================================================================
module tb_hamming_secded_dec_pipe;

    localparam int DW     = 11;
    localparam int NC     = 4;
    localparam int CW     = 16;
    localparam int CNTW   = 16;
    localparam int CNTW_S = 2;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            in_valid_i;
    logic [CW-1:0]   cw_i;
    logic            out_ready_i;
    logic            clr_cnt_i;

    logic            in_ready, out_valid, ce, ue;
    logic [DW-1:0]   data;
    logic [CNTW-1:0] ce_cnt, ue_cnt;
    logic [NC-1:0]   last_syn;

    logic              in_ready_s, out_valid_s, ce_s, ue_s;
    logic [DW-1:0]     data_s;
    logic [CNTW_S-1:0] ce_cnt_s, ue_cnt_s;
    logic [NC-1:0]     last_syn_s;

    always #5 clk = ~clk;

    hamming_secded_dec_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CNTW)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready),
        .cw_i(cw_i), .out_valid_o(out_valid), .out_ready_i(out_ready_i),
        .data_o(data), .ce_o(ce), .ue_o(ue), .ce_cnt_o(ce_cnt), .ue_cnt_o(ue_cnt),
        .last_syn_o(last_syn), .clr_cnt_i(clr_cnt_i)
    );

    hamming_secded_dec_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CNTW_S)) dut_s (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_s),
        .cw_i(cw_i), .out_valid_o(out_valid_s), .out_ready_i(out_ready_i),
        .data_o(data_s), .ce_o(ce_s), .ue_o(ue_s), .ce_cnt_o(ce_cnt_s), .ue_cnt_o(ue_cnt_s),
        .last_syn_o(last_syn_s), .clr_cnt_i(clr_cnt_i)
    );

    typedef struct {
        logic [DW-1:0] data;
        bit            ce;
        bit            ue;
        int            syn;
    } item_t;

    item_t q[$];
    int    age_q[$];
    int    ce_n, ue_n, last_m;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic bit is_data_pos(input int p);
        return (p & (p - 1)) != 0;
    endfunction

    // Builds a valid codeword: data in non-power-of-two slots, check bits zero the syndrome.
    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] w;
        int k, s;
        w = '0; k = 0; s = 0;
        for (int p = 1; p < CW; p++) begin
            if (is_data_pos(p)) begin
                w[p] = d[k];
                if (d[k]) s = s ^ p;
                k++;
            end
        end
        for (int b = 0; b < NC; b++) w[1 << b] = s[b];
        w[0] = ^w[CW-1:1];
        return w;
    endfunction

    function automatic item_t ref_decode(input logic [CW-1:0] w);
        item_t it;
        int s, k;
        bit p;
        logic [CW-1:0] fx;
        s = 0; p = 0;
        for (int i = 0; i < CW; i++) begin
            if (w[i]) begin
                p = ~p;
                if (i > 0) s = s ^ i;
            end
        end
        it.syn = s;
        it.ce  = p && (s < CW);
        it.ue  = (p && (s >= CW)) || (!p && (s != 0));
        fx = w;
        if (it.ce && (s != 0)) fx[s] = ~fx[s];
        k = 0;
        it.data = '0;
        for (int i = 1; i < CW; i++) begin
            if (is_data_pos(i)) begin
                it.data[k] = fx[i];
                k++;
            end
        end
        return it;
    endfunction

    function automatic logic [CW-1:0] gen_word();
        logic [CW-1:0] w;
        int a, b;
        w = encode(DW'($urandom));
        case ($urandom_range(0, 3))
            0: ;
            1: begin
                a = $urandom_range(0, CW - 1);
                w[a] = ~w[a];
            end
            2: begin
                a = $urandom_range(0, CW - 1);
                b = (a + $urandom_range(1, CW - 1)) % CW;
                w[a] = ~w[a];
                w[b] = ~w[b];
            end
            default: w = CW'($urandom);
        endcase
        return w;
    endfunction

    // One cycle: drive at the falling edge, check 1ns later, then advance the model.
    task automatic step(input bit v, input logic [CW-1:0] w, input bit ordy, input bit clr);
        bit    exp_valid, exp_ready, in_hs, out_hs;
        item_t it;
        in_valid_i  = v;
        cw_i        = w;
        out_ready_i = ordy;
        clr_cnt_i   = clr;
        #1;
        exp_valid = (q.size() > 0) && (age_q[0] >= 2);
        exp_ready = (q.size() < 2) || ordy;
        check_val("out_valid", out_valid, exp_valid);
        check_val("out_valid_s", out_valid_s, exp_valid);
        check_val("in_ready", in_ready, exp_ready);
        check_val("in_ready_s", in_ready_s, exp_ready);
        check_val("ce_cnt", ce_cnt, sat(ce_n, CNTW));
        check_val("ue_cnt", ue_cnt, sat(ue_n, CNTW));
        check_val("ce_cnt_s", ce_cnt_s, sat(ce_n, CNTW_S));
        check_val("ue_cnt_s", ue_cnt_s, sat(ue_n, CNTW_S));
        check_val("last_syn", last_syn, last_m);
        check_val("last_syn_s", last_syn_s, last_m);
        if (exp_valid) begin
            check_val("data", data, q[0].data);
            check_val("ce", ce, q[0].ce);
            check_val("ue", ue, q[0].ue);
            check_val("data_s", data_s, q[0].data);
        end
        in_hs  = v && exp_ready;
        out_hs = exp_valid && ordy;
        if (out_hs) begin
            it = q.pop_front();
            void'(age_q.pop_front());
        end
        if (clr) begin
            ce_n = 0; ue_n = 0; last_m = 0;
        end else if (out_hs) begin
            if (it.ce) ce_n++;
            if (it.ue) ue_n++;
            if (it.ce || it.ue) last_m = it.syn;
        end
        if (in_hs) begin
            q.push_back(ref_decode(w));
            age_q.push_back(0);
        end
        foreach (age_q[i]) age_q[i] = age_q[i] + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_valid_s", out_valid_s, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_data", data, 0);
        check_val("rst_ce", ce, 0);
        check_val("rst_ue", ue, 0);
        check_val("rst_ce_cnt", ce_cnt, 0);
        check_val("rst_ue_cnt", ue_cnt, 0);
        check_val("rst_last_syn", last_syn, 0);
        q.delete();
        age_q.delete();
        ce_n = 0; ue_n = 0; last_m = 0;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] w;
        rst_i = 1'b1; in_valid_i = 1'b0; cw_i = '0; out_ready_i = 1'b0; clr_cnt_i = 1'b0;
        ce_n = 0; ue_n = 0; last_m = 0;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Directed words from the decode rules.
        step(1, 16'hFFFF, 1, 0);
        step(1, 16'h0020, 1, 0);
        step(1, 16'h0001, 1, 0);
        step(1, 16'h0060, 1, 0);
        repeat (3) step(0, '0, 1, 0);
        check_val("dir_ce_cnt", ce_cnt, 2);
        check_val("dir_ue_cnt", ue_cnt, 1);
        check_val("dir_last_syn", last_syn, 3);

        // Back-pressure: third word waits until the consumer frees a slot.
        step(1, gen_word(), 0, 0);
        step(1, gen_word(), 0, 0);
        w = gen_word();
        step(1, w, 0, 0);
        check_val("bp_in_ready", in_ready, 0);
        step(1, w, 0, 0);
        step(1, w, 1, 0);
        repeat (4) step(0, '0, 1, 0);

        // Saturation of the 2-bit counter.
        repeat (5) begin
            w = encode(DW'($urandom));
            w[$urandom_range(1, CW - 1)] ^= 1'b1;
            step(1, w, 1, 0);
        end
        repeat (3) step(0, '0, 1, 0);
        check_val("sat_ce_cnt_s", ce_cnt_s, 3);

        // Clear on the same cycle as a CE handshake wins.
        w = encode(DW'($urandom));
        w[5] ^= 1'b1;
        step(1, w, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 1);
        check_val("clr_ce_cnt", ce_cnt, 0);
        check_val("clr_ce_cnt_s", ce_cnt_s, 0);
        check_val("clr_last_syn", last_syn, 0);

        // Random traffic with a mid-stream reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step(($urandom_range(0, 9) < 7), gen_word(),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3));
        end
        repeat (4) step(0, '0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hamming_secded_dec_pipe
`default_nettype wire
